// File: rtl/rr_arb4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb4_pkg
//  Description : Shared widths, limits and FSM encoding for the 4-requester
//                round-robin arbiter and its picker.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_arb4_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int CNT_W   = 8;

   // Ceiling of the saturating hold counter and of the per-requester counters.
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage : rr_arb4_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational rotating-priority picker. Returns the first set
//                bit of mask scanning ptr, ptr+1, ... wrapping mod 4.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick4
   import rr_arb4_pkg::*;
(
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [IDX_W-1:0] w_pos;

   // Scan from the farthest offset back to ptr so the closest set bit wins.
   always_comb begin
      idx   = ptr;
      any   = |mask;
      w_pos = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_pos = ptr + IDX_W'(k);
         if (mask[w_pos]) begin
            idx = w_pos;
         end
      end
   end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_arb4_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb4_sel
//  Description : 4-requester round-robin arbiter with grant hold and forced
//                rotation after HOLD_MAX cycles. Produces a grant index and
//                enable intended for a 2-to-4 decoder. All outputs registered.
//                Optional per-requester grant counters under the macro
//                RR_ARB4_STATS_EN (adds stats_clr input, grant_stats output).
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb4_sel
   import rr_arb4_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int PTR_INIT = 0
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB4_STATS_EN
   input  logic               stats_clr,
   output logic [31:0]        grant_stats,
`endif
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_en,
   output logic               grant_new,
   output logic [CNT_W-1:0]   hold_cnt
);

   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);
   localparam logic [IDX_W-1:0] C_PTR_INIT  = IDX_W'(PTR_INIT);

   arb_state_e         r_state;
   logic [IDX_W-1:0]   r_ptr;

   arb_state_e         w_state_nxt;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               w_en_nxt;
   logic               w_new_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_take;

   logic [NUM_REQ-1:0] w_others;
   logic [NUM_REQ-1:0] w_mask;
   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_any;

   // Requesters other than the current holder; in IDLE the whole req vector
   // competes, so one picker serves both states.
   assign w_others = req & ~(NUM_REQ'(1) << grant_idx);
   assign w_mask   = (r_state == IDLE) ? req : w_others;

   rr_pick4 u_pick (
      .mask (w_mask),
      .ptr  (r_ptr),
      .idx  (w_pick_idx),
      .any  (w_pick_any)
   );

   // Next-state and next-output decision: new grant, release to idle, or hold.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = grant_idx;
      w_en_nxt    = grant_en;
      w_new_nxt   = 1'b0;
      w_cnt_nxt   = hold_cnt;
      w_take      = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_take = 1'b1;
            end else begin
               w_en_nxt = 1'b0;
            end
         end
         GRANT: begin
            if (!req[grant_idx]) begin
               // Release takes precedence over a coincident hold expiry.
               if (w_pick_any) begin
                  w_take = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_en_nxt    = 1'b0;
                  w_cnt_nxt   = '0;
               end
            end else if ((hold_cnt == C_HOLD_LAST) && w_pick_any) begin
               w_take = 1'b1;
            end else if (hold_cnt != CNT_MAX) begin
               w_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_en_nxt    = 1'b0;
         end
      endcase

      // The new grantee drops to lowest priority for the next decision.
      if (w_take) begin
         w_state_nxt = GRANT;
         w_idx_nxt   = w_pick_idx;
         w_en_nxt    = 1'b1;
         w_new_nxt   = 1'b1;
         w_cnt_nxt   = '0;
         w_ptr_nxt   = w_pick_idx + IDX_W'(1);
      end
   end

   // State, pointer and registered outputs; async assert of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= C_PTR_INIT;
         grant_idx <= '0;
         grant_en  <= 1'b0;
         grant_new <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         grant_idx <= w_idx_nxt;
         grant_en  <= w_en_nxt;
         grant_new <= w_new_nxt;
         hold_cnt  <= w_cnt_nxt;
      end
   end

`ifdef RR_ARB4_STATS_EN
   logic [CNT_W-1:0] r_stat_cnt [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      // Saturating count of grants issued to requester i; clear wins.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stat_cnt[i] <= '0;
         end else if (stats_clr) begin
            r_stat_cnt[i] <= '0;
         end else if (grant_new && (grant_idx == IDX_W'(i)) &&
                      (r_stat_cnt[i] != CNT_MAX)) begin
            r_stat_cnt[i] <= r_stat_cnt[i] + CNT_W'(1);
         end
      end
      assign grant_stats[i*CNT_W +: CNT_W] = r_stat_cnt[i];
   end
`endif

endmodule : rr_arb4_sel
`default_nettype wire
